// File: rtl/cdb_writeback_arbiter_if.sv
// Bundle between functional units and the CDB writeback arbiter.
// Latency: none; this is only signal grouping.
// Backpressure: fu_grant is the only flow control, and requests hold until granted.
interface cdb_writeback_arbiter_if #(
   parameter int WORD_SIZE  = 32,
   parameter int RB_SIZE    = 8,
   parameter int RB_INDEX   = 3,
   parameter int FU_NUM     = 4,
   parameter int CDB_PORTS  = 2,
   parameter int STORER_NUM = 1
);
   logic [FU_NUM-1:0]               fu_req;
   logic [FU_NUM*WORD_SIZE-1:0]     fu_data;
   logic [FU_NUM*RB_INDEX-1:0]      fu_index;
   logic [STORER_NUM*WORD_SIZE-1:0] addr_bus;
   logic [RB_SIZE-1:0]              rb_clear;
   logic                            flush;
   logic [FU_NUM-1:0]               fu_grant;
   logic [CDB_PORTS-1:0]            cdb_valid;
   logic [CDB_PORTS*RB_INDEX-1:0]   cdb_index;
   logic [CDB_PORTS*WORD_SIZE-1:0]  cdb_data;
   logic [RB_SIZE*WORD_SIZE-1:0]    CDB_data_data;
   logic [RB_SIZE-1:0]              CDB_data_valid;
   logic [RB_SIZE*WORD_SIZE-1:0]    CDB_data_addr;
   logic                            index_conflict;

   // FU / pipeline side
   modport master (
      output fu_req, fu_data, fu_index, addr_bus, rb_clear, flush,
      input  fu_grant, cdb_valid, cdb_index, cdb_data,
      input  CDB_data_data, CDB_data_valid, CDB_data_addr, index_conflict
   );

   // Arbiter side
   modport slave (
      input  fu_req, fu_data, fu_index, addr_bus, rb_clear, flush,
      output fu_grant, cdb_valid, cdb_index, cdb_data,
      output CDB_data_data, CDB_data_valid, CDB_data_addr, index_conflict
   );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Round-robin arbiter granting up to CDB_PORTS FU results per cycle onto the CDB and into per-entry result storage.
// Latency: grant is combinational; broadcast and entry write appear 1 cycle after the grant.
// Backpressure: an ungranted FU holds its request; flush and reset suppress all grants.
module cdb_writeback_arbiter #(
   parameter int WORD_SIZE  = 32,
   parameter int RB_SIZE    = 8,
   parameter int RB_INDEX   = 3,
   parameter int FU_NUM     = 4,
   parameter int CDB_PORTS  = 2,
   parameter int STORER_NUM = 1
) (
   input logic                    clk,
   input logic                    reset,
   cdb_writeback_arbiter_if.slave io
);
   localparam int STORER_START = FU_NUM - STORER_NUM;
   localparam int FU_W         = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
   localparam int PW           = (CDB_PORTS > 1) ? $clog2(CDB_PORTS) : 1;

   logic [FU_W-1:0]      rr_ptr;
   logic [FU_NUM-1:0]    grant;
   logic [CDB_PORTS-1:0] port_vld;
   logic [FU_W-1:0]      port_fu   [CDB_PORTS];
   logic [RB_INDEX-1:0]  port_idx  [CDB_PORTS];
   logic [WORD_SIZE-1:0] port_dat  [CDB_PORTS];
   logic [WORD_SIZE-1:0] port_addr [CDB_PORTS];
   logic [CDB_PORTS-1:0] port_st;
   logic                 any_grant;
   logic [FU_W-1:0]      last_fu;
   logic                 conflict;

   logic [RB_INDEX-1:0]  fu_idx_a   [FU_NUM];
   logic [WORD_SIZE-1:0] fu_dat_a   [FU_NUM];
   logic [WORD_SIZE-1:0] st_addr_a  [STORER_NUM];

   logic [CDB_PORTS-1:0] cdb_valid_q;
   logic [RB_INDEX-1:0]  cdb_index_q [CDB_PORTS];
   logic [WORD_SIZE-1:0] cdb_data_q  [CDB_PORTS];
   logic [WORD_SIZE-1:0] entry_data  [RB_SIZE];
   logic [WORD_SIZE-1:0] entry_addr  [RB_SIZE];
   logic [RB_SIZE-1:0]   entry_valid;
   logic                 conflict_q;

   // Unpack the flat FU buses so they can be selected by FU number.
   for (genvar f = 0; f < FU_NUM; f++) begin : g_fu
      assign fu_idx_a[f] = io.fu_index[f*RB_INDEX +: RB_INDEX];
      assign fu_dat_a[f] = io.fu_data[f*WORD_SIZE +: WORD_SIZE];
   end
   for (genvar s = 0; s < STORER_NUM; s++) begin : g_st
      assign st_addr_a[s] = io.addr_bus[s*WORD_SIZE +: WORD_SIZE];
   end

   // Scan FUs upward from rr_ptr; the k-th requester found takes CDB port k.
   always_comb begin
      int cnt;
      cnt       = 0;
      grant     = '0;
      port_vld  = '0;
      any_grant = 1'b0;
      last_fu   = '0;
      for (int p = 0; p < CDB_PORTS; p++) port_fu[p] = '0;
      for (int i = 0; i < FU_NUM; i++) begin
         int f;
         f = (int'(rr_ptr) + i) % FU_NUM;
         if (!reset && !io.flush && io.fu_req[FU_W'(f)] && cnt < CDB_PORTS) begin
            grant[FU_W'(f)]    = 1'b1;
            port_vld[PW'(cnt)] = 1'b1;
            port_fu[PW'(cnt)]  = FU_W'(f);
            last_fu            = FU_W'(f);
            any_grant          = 1'b1;
            cnt                = cnt + 1;
         end
      end
   end

   // Per-port payload select, storer address select and same-entry conflict detect.
   always_comb begin
      conflict = 1'b0;
      for (int p = 0; p < CDB_PORTS; p++) begin
         port_idx[p]  = fu_idx_a[port_fu[p]];
         port_dat[p]  = fu_dat_a[port_fu[p]];
         port_st[p]   = (int'(port_fu[p]) >= STORER_START);
         port_addr[p] = '0;
         for (int s = 0; s < STORER_NUM; s++) begin
            if (int'(port_fu[p]) == STORER_START + s) port_addr[p] = st_addr_a[s];
         end
         for (int q = p + 1; q < CDB_PORTS; q++) begin
            if (port_vld[p] && port_vld[q] && port_idx[p] == port_idx[q]) conflict = 1'b1;
         end
      end
   end

   // Broadcast registers, entry writes (later port wins), commit clears and pointer update.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr      <= '0;
         cdb_valid_q <= '0;
         conflict_q  <= 1'b0;
         entry_valid <= '0;
         cdb_index_q <= '{default: '0};
         cdb_data_q  <= '{default: '0};
         entry_data  <= '{default: '0};
         entry_addr  <= '{default: '0};
      end else if (io.flush) begin
         rr_ptr      <= '0;
         cdb_valid_q <= '0;
         conflict_q  <= 1'b0;
         entry_valid <= '0;
      end else begin
         if (any_grant) rr_ptr <= (int'(last_fu) == FU_NUM - 1) ? '0 : last_fu + 1'b1;
         cdb_valid_q <= port_vld;
         conflict_q  <= conflict;
         entry_valid <= entry_valid & ~io.rb_clear;
         for (int p = 0; p < CDB_PORTS; p++) begin
            if (port_vld[p]) begin
               cdb_index_q[p]          <= port_idx[p];
               cdb_data_q[p]           <= port_dat[p];
               entry_data[port_idx[p]] <= port_dat[p];
               entry_valid[port_idx[p]] <= 1'b1;
               if (port_st[p]) entry_addr[port_idx[p]] <= port_addr[p];
            end
         end
      end
   end

   assign io.fu_grant       = grant;
   assign io.cdb_valid      = cdb_valid_q;
   assign io.CDB_data_valid = entry_valid;
   assign io.index_conflict = conflict_q;

   for (genvar p = 0; p < CDB_PORTS; p++) begin : g_port
      assign io.cdb_index[p*RB_INDEX +: RB_INDEX]  = cdb_index_q[p];
      assign io.cdb_data[p*WORD_SIZE +: WORD_SIZE] = cdb_data_q[p];
   end
   for (genvar e = 0; e < RB_SIZE; e++) begin : g_entry
      assign io.CDB_data_data[e*WORD_SIZE +: WORD_SIZE] = entry_data[e];
      assign io.CDB_data_addr[e*WORD_SIZE +: WORD_SIZE] = entry_addr[e];
   end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for the CDB writeback arbiter: vector table plus hand sequences, scoreboarded per cycle.
// Latency: expects broadcast/entry updates one edge after the grant.
// Backpressure: held requests are re-driven by the sequences until granted.
module tb_cdb_writeback_arbiter;
   logic clk;
   logic reset;

   cdb_writeback_arbiter_if #(.WORD_SIZE(32), .RB_SIZE(8), .RB_INDEX(3),
                              .FU_NUM(4), .CDB_PORTS(2), .STORER_NUM(1)) bus ();

   cdb_writeback_arbiter #(.WORD_SIZE(32), .RB_SIZE(8), .RB_INDEX(3),
                           .FU_NUM(4), .CDB_PORTS(2), .STORER_NUM(1)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] e_grant;
      logic [1:0] e_vld;
      int         e_fu0;
      int         e_fu1;
   } vec_t;

   typedef struct {
      logic [1:0]  vld;
      logic [2:0]  idx0;
      logic [2:0]  idx1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        conf;
   } sb_t;

   sb_t         sbq[$];
   vec_t        tbl[8];
   logic [31:0] m_data[8];
   logic [31:0] m_addr[8];
   logic [7:0]  m_valid;
   logic [2:0]  h_idx[2];
   logic [31:0] h_dat[2];
   int          n_cmp;
   int          n_bad;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int e = 0; e < 8; e++) begin
         m_data[e] = '0;
         m_addr[e] = '0;
      end
      m_valid = '0;
      for (int p = 0; p < 2; p++) begin
         h_idx[p] = '0;
         h_dat[p] = '0;
      end
      sbq.delete();
   endtask

   task automatic chk_entries(input string tag);
      logic [255:0] fd;
      logic [255:0] fa;
      fd = '0;
      fa = '0;
      for (int e = 0; e < 8; e++) begin
         fd[e*32 +: 32] = m_data[e];
         fa[e*32 +: 32] = m_addr[e];
      end
      chk({tag, ".CDB_data_valid"}, bus.CDB_data_valid, m_valid);
      chk({tag, ".CDB_data_data"}, bus.CDB_data_data, fd);
      chk({tag, ".CDB_data_addr"}, bus.CDB_data_addr, fa);
   endtask

   // Hold reset for ncyc cycles with req pending; everything must read back zero.
   task automatic do_reset(input int ncyc, input logic [3:0] req);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         reset = 1'b1;
         bus.fu_req = req;
         bus.rb_clear = '0;
         bus.flush = 1'b0;
         #1 chk("reset.fu_grant", bus.fu_grant, 4'b0000);
         @(posedge clk);
         #1;
         model_clear();
         chk("reset.cdb_valid", bus.cdb_valid, 2'b00);
         chk("reset.index_conflict", bus.index_conflict, 1'b0);
         chk("reset.cdb_index", bus.cdb_index, 6'd0);
         chk("reset.cdb_data", bus.cdb_data, 64'd0);
         chk_entries("reset");
      end
      @(negedge clk);
      reset = 1'b0;
      bus.fu_req = '0;
   endtask

   // Drive one cycle, check the grant, record expected results, check them after the edge.
   task automatic cycle(input string tag, input logic [3:0] req, input logic [11:0] idx,
                        input logic [127:0] dat, input logic [31:0] addr, input logic [7:0] clr,
                        input logic fl, input logic [3:0] e_grant, input logic [1:0] e_vld,
                        input int e_fu0, input int e_fu1, input logic e_conf);
      sb_t e;
      sb_t got;
      @(negedge clk);
      bus.fu_req   = req;
      bus.fu_index = idx;
      bus.fu_data  = dat;
      bus.addr_bus = addr;
      bus.rb_clear = clr;
      bus.flush    = fl;
      #1 chk({tag, ".fu_grant"}, bus.fu_grant, e_grant);
      e.vld  = e_vld;
      e.conf = e_conf;
      e.idx0 = idx[e_fu0*3 +: 3];
      e.d0   = dat[e_fu0*32 +: 32];
      e.idx1 = idx[e_fu1*3 +: 3];
      e.d1   = dat[e_fu1*32 +: 32];
      if (fl) begin
         m_valid = '0;
      end else begin
         m_valid = m_valid & ~clr;
         if (e_vld[0]) begin
            m_data[e.idx0] = e.d0;
            m_valid[e.idx0] = 1'b1;
            if (e_fu0 == 3) m_addr[e.idx0] = addr;
         end
         if (e_vld[1]) begin
            m_data[e.idx1] = e.d1;
            m_valid[e.idx1] = 1'b1;
            if (e_fu1 == 3) m_addr[e.idx1] = addr;
         end
      end
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
      end else begin
         got = sbq.pop_front();
         chk({tag, ".cdb_valid"}, bus.cdb_valid, got.vld);
         chk({tag, ".index_conflict"}, bus.index_conflict, got.conf);
         if (got.vld[0]) begin
            h_idx[0] = got.idx0;
            h_dat[0] = got.d0;
         end
         if (got.vld[1]) begin
            h_idx[1] = got.idx1;
            h_dat[1] = got.d1;
         end
         chk({tag, ".cdb_index"}, bus.cdb_index, {h_idx[1], h_idx[0]});
         chk({tag, ".cdb_data"}, bus.cdb_data, {h_dat[1], h_dat[0]});
         chk_entries(tag);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0]  tidx;
      logic [127:0] tdat;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.fu_req = 4'b1111;
      bus.fu_index = '0;
      bus.fu_data = '0;
      bus.addr_bus = '0;
      bus.rb_clear = '0;
      bus.flush = 1'b0;

      // Round-robin table; starts with the pointer at 3 after the single-request case.
      tbl[0] = '{4'b1111, 4'b1001, 2'b11, 3, 0};
      tbl[1] = '{4'b0110, 4'b0110, 2'b11, 1, 2};
      tbl[2] = '{4'b0000, 4'b0000, 2'b00, 0, 0};
      tbl[3] = '{4'b0001, 4'b0001, 2'b01, 0, 0};
      tbl[4] = '{4'b1101, 4'b1100, 2'b11, 2, 3};
      tbl[5] = '{4'b0011, 4'b0011, 2'b11, 0, 1};
      tbl[6] = '{4'b0001, 4'b0001, 2'b01, 0, 0};
      tbl[7] = '{4'b1000, 4'b1000, 2'b01, 3, 0};

      do_reset(2, 4'b1111);

      cycle("single", 4'b0100, 12'h140, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 32'h0,
            8'h00, 1'b0, 4'b0100, 2'b01, 2, 0, 1'b0);

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) begin
            tidx[i*3 +: 3]  = 3'((k*3 + i) % 8);
            tdat[i*32 +: 32] = 32'hA000_0000 + 32'(k*256 + i);
         end
         cycle($sformatf("tbl%0d", k), tbl[k].req, tidx, tdat, 32'h4000 + 32'(k), 8'h00,
               1'b0, tbl[k].e_grant, tbl[k].e_vld, tbl[k].e_fu0, tbl[k].e_fu1, 1'b0);
      end

      tidx = {3'd3, 3'd2, 3'd1, 3'd0};
      tdat = {32'h13, 32'h12, 32'h11, 32'h10};
      cycle("rr1", 4'b1111, tidx, tdat, 32'h200, 8'h00, 1'b0, 4'b0011, 2'b11, 0, 1, 1'b0);
      cycle("rr2", 4'b1100, tidx, tdat, 32'h200, 8'h00, 1'b0, 4'b1100, 2'b11, 2, 3, 1'b0);

      cycle("store", 4'b1000, {3'd2, 9'd0}, {32'd7, 96'd0}, 32'h100, 8'h00, 1'b0,
            4'b1000, 2'b01, 3, 0, 1'b0);
      cycle("nonstore", 4'b0001, {9'd0, 3'd2}, {96'd0, 32'd9}, 32'h555, 8'h00, 1'b0,
            4'b0001, 2'b01, 0, 0, 1'b0);

      cycle("flush", 4'b0001, {9'd0, 3'd6}, {96'd0, 32'h66}, 32'h0, 8'h00, 1'b1,
            4'b0000, 2'b00, 0, 0, 1'b0);

      cycle("conflict", 4'b0011, {6'd0, 3'd4, 3'd4}, {64'd0, 32'd2, 32'd1}, 32'h0, 8'h10,
            1'b0, 4'b0011, 2'b11, 0, 1, 1'b1);
      cycle("clear", 4'b0000, 12'd0, 128'd0, 32'h0, 8'h10, 1'b0, 4'b0000, 2'b00, 0, 0, 1'b0);

      do_reset(1, 4'b0001);
      cycle("post_reset", 4'b0000, 12'd0, 128'd0, 32'h0, 8'h00, 1'b0,
            4'b0000, 2'b00, 0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cdb_writeback_arbiter.md
CDB_WRITEBACK_ARBITER -- requirements
Module: cdb_writeback_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, data and address word width.
REQ-002 Parameter RB_SIZE, default 8, reorder-buffer entry count; it SHALL equal 2**RB_INDEX.
REQ-003 Parameter RB_INDEX, default 3, reorder-buffer index width.
REQ-004 Parameter FU_NUM, default 4, functional-unit count.
REQ-005 Parameter CDB_PORTS, default 2, broadcast ports per cycle; 1 <= CDB_PORTS <= FU_NUM.
REQ-006 Parameter STORER_NUM, default 1, storer count; storers SHALL be the highest-numbered FUs, starting at STORER_START = FU_NUM-STORER_NUM.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 fu_req  in  FU_NUM  FU i has a result to broadcast.
REQ-010 fu_data  in  FU_NUM*WORD_SIZE  result of FU i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-011 fu_index  in  FU_NUM*RB_INDEX  destination RB entry of FU i.
REQ-012 addr_bus  in  STORER_NUM*WORD_SIZE  store address of storer s.
REQ-013 rb_clear  in  RB_SIZE  commit clear per entry.
REQ-014 flush  in  1  pipeline flush.
REQ-015 fu_grant  out  FU_NUM  combinational grant.
REQ-016 cdb_valid  out  CDB_PORTS  registered broadcast strobe per port.
REQ-017 cdb_index  out  CDB_PORTS*RB_INDEX  broadcast entry per port.
REQ-018 cdb_data  out  CDB_PORTS*WORD_SIZE  broadcast data per port.
REQ-019 CDB_data_data  out  RB_SIZE*WORD_SIZE  per-entry result.
REQ-020 CDB_data_valid  out  RB_SIZE  per-entry result valid.
REQ-021 CDB_data_addr  out  RB_SIZE*WORD_SIZE  per-entry store address.
REQ-022 index_conflict  out  1  registered one-cycle error pulse.

Function
REQ-023 Grants SHALL be round-robin: scan FUs from rr_ptr upward, mod FU_NUM, and grant the first min(CDB_PORTS, requester count) requesting FUs; the k-th grant maps to CDB port k.
REQ-024 fu_grant SHALL be combinational from fu_req, rr_ptr and flush; a granted FU drops or replaces its request next cycle, and an ungranted FU holds req, data, index and addr stable.
REQ-025 rr_ptr SHALL advance to (last granted FU + 1) mod FU_NUM at each rising edge with at least one grant, and otherwise stay unchanged.
REQ-026 For each grant in cycle N, the rising edge ending N SHALL write the entry: CDB_data_data[idx] = data, CDB_data_valid[idx] = 1, and drive cdb_valid/index/data on that port; latency is 1 cycle.
REQ-027 cdb_valid SHALL be a one-cycle pulse; an unused port SHALL show cdb_valid = 0 with cdb_index/cdb_data held.
REQ-028 A granted storer SHALL also write CDB_data_addr[idx] = its addr_bus word; a non-storer write SHALL leave CDB_data_addr[idx] unchanged.
REQ-029 rb_clear[j] SHALL zero CDB_data_valid[j] at the rising edge; a grant write to the same entry in the same cycle SHALL win (valid = 1).
REQ-030 If two grants in one cycle target the same idx, the higher-numbered port SHALL win for CDB_data_*, both ports SHALL still broadcast, and index_conflict SHALL pulse next cycle.
REQ-031 When flush = 1: fu_grant SHALL be 0 that cycle; at the edge all CDB_data_valid, cdb_valid and index_conflict SHALL go to 0 and rr_ptr to 0; CDB_data_data and CDB_data_addr SHALL be retained.
REQ-032 Entries not written or cleared SHALL hold their value.

Reset
REQ-033 With reset = 1 at a rising edge, every output register, rr_ptr, CDB_data_data and CDB_data_addr SHALL become 0, and fu_grant SHALL be 0 while reset is high.
REQ-034 reset SHALL override flush, rb_clear and grants; requests pending at reset SHALL be dropped unless reasserted after reset.

Verification
REQ-035 Reset: assert reset 2 cycles with fu_req=1111 -> all outputs 0, fu_grant=0000 throughout.
REQ-036 Single: FU2 req, idx=5, data=32'hDEADBEEF -> fu_grant=0100; next cycle CDB_data_valid[5]=1, CDB_data_data[5]=DEADBEEF, cdb_valid=01, cdb_index[0]=5; rr_ptr=3.
REQ-037 Round-robin: from rr_ptr=0, fu_req=1111 held until granted, idx=0..3 -> grants 0011 then 1100; entries 0..3 valid after 2 edges; rr_ptr=0.
REQ-038 Storer: FU3 idx=2, data=7, addr=32'h100 -> CDB_data_addr[2]=100, CDB_data_data[2]=7; later FU0 to idx=2 keeps addr 100.
REQ-039 Conflict/clear: FU0 (data 1) and FU1 (data 2) both idx=4 with rb_clear[4]=1 -> CDB_data_data[4]=2, CDB_data_valid[4]=1, index_conflict pulses once.
REQ-040 Flush: entries 1,3 valid, fu_req=0001, flush=1 -> fu_grant=0000; next cycle CDB_data_valid=0, data retained; FU0 granted the cycle after.
